// File: rtl/hstl_iv_rx_capture_pkg.sv
// hstl_iv_rx_capture_pkg: receive-window state encodings shared by the capture top level
package hstl_iv_rx_capture_pkg;
  typedef enum logic [1:0] {
    RX   = 2'd0,
    TX   = 2'd1,
    TURN = 2'd2
  } win_t;
endpackage

// File: rtl/hstl_rx_filter.sv
// hstl_rx_filter: consecutive-sample glitch filter; C/R/CE clock-reset-enable, en = receive window, s = synced pad level, O/RISE/FALL/GLITCH outputs
module hstl_rx_filter #(
  parameter int   FILTER_LEN = 3,
  parameter logic INIT       = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic en,
  input  logic s,
  output logic O,
  output logic RISE,
  output logic FALL,
  output logic GLITCH
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge C) begin
    if (R) begin
      O      <= INIT;
      cnt    <= '0;
      RISE   <= 1'b0;
      FALL   <= 1'b0;
      GLITCH <= 1'b0;
    end else begin
      RISE   <= 1'b0;
      FALL   <= 1'b0;
      GLITCH <= 1'b0;
      if (CE) begin
        if (!en) cnt <= '0;
        else if (s != O) begin
          if (cnt == LAST) begin
            O    <= s;
            cnt  <= '0;
            RISE <= s;
            FALL <= ~s;
          end else cnt <= cnt + 1'b1;
        end else if (cnt != '0) begin
          cnt    <= '0;
          GLITCH <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/hstl_iv_rx_capture.sv
// hstl_iv_rx_capture: pad receive path with synchroniser, driver-aware blanking window and glitch filter; C/R/CE, I pad in, T local tristate, O/RISE/FALL/GLITCH/VALID out
module hstl_iv_rx_capture
  import hstl_iv_rx_capture_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter int   TURNAROUND  = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic I,
  input  logic T,
  output logic O,
  output logic RISE,
  output logic FALL,
  output logic GLITCH,
  output logic VALID
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
    $error("FILTER_LEN out of range 1..15");
  end
  if (TURNAROUND < 0 || TURNAROUND > 15) begin : g_bad_turn
    $error("TURNAROUND out of range 0..15");
  end
  // Global tristate is a pulled-low net that is idle outside configuration, so it reads as 0 here.
  logic gts;
  assign gts = 1'b0;
  logic drive;
  assign drive = ~T & ~gts;
  logic [SYNC_STAGES-1:0] sync;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge C) begin
    if (R) sync <= {SYNC_STAGES{INIT}};
    else if (CE) sync <= {sync[SYNC_STAGES-2:0], I};
  end
  win_t state, state_nxt;
  logic [3:0] tcnt, tcnt_nxt;
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    unique case (state)
      RX: state_nxt = drive ? TX : RX;
      TX:
        if (!drive) begin
          state_nxt = (TURNAROUND > 0) ? TURN : RX;
          tcnt_nxt  = 4'(TURNAROUND - 1);
        end
      TURN:
        if (drive) state_nxt = TX;
        else if (tcnt == 4'd0) state_nxt = RX;
        else tcnt_nxt = tcnt - 4'd1;
      default: state_nxt = RX;
    endcase
  end
  always_ff @(posedge C) begin
    if (R) begin
      state <= RX;
      tcnt  <= 4'd0;
    end else if (CE) begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end
  assign VALID = (state == RX);
  // Masking with drive keeps O frozen when the driver turns on in the very cycle a count would complete.
  hstl_rx_filter #(
    .FILTER_LEN(FILTER_LEN),
    .INIT      (INIT)
  ) u_filter (
    .C     (C),
    .R     (R),
    .CE    (CE),
    .en    ((state == RX) & ~drive),
    .s     (s),
    .O     (O),
    .RISE  (RISE),
    .FALL  (FALL),
    .GLITCH(GLITCH)
  );
endmodule
